// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dma_pkg;

  // FSM encoding is fixed so that state values stay stable across revisions.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Each transferred word advances a pointer by this many bytes.
  localparam int WORD_BYTES = 4;

  // A byte address is usable only when it points at a word boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// Word-by-word memory-to-memory copier that drives the data-memory port like the CPU.
// Latency: start at edge k -> first read cycle k+1, last write cycle k+2N, done in cycle k+2N+1.
// Backpressure: none; the port owner is chosen externally and start is ignored outside IDLE.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]  ONE_WORD = LEN_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       data_reg;

  logic misaligned;
  logic last_word;

  // Request qualification: either address off a word boundary aborts before any access.
  assign misaligned = !is_word_aligned(src_addr[1:0]) || !is_word_aligned(dst_addr[1:0]);
  assign last_word  = (remaining == ONE_WORD);

  // State register; reset drops straight back to IDLE so no further write can issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and memory-port drive; outputs are pure functions of state and registers.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_wd      = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (misaligned) begin
            state_nxt = S_DONE;
          end else if (word_count == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        busy        = 1'b1;
        mem_address = src_ptr;
        state_nxt   = S_WR;
      end
      S_WR: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        mem_address = dst_ptr;
        mem_wd      = data_reg;
        state_nxt   = last_word ? S_DONE : S_RD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the request in IDLE, capture read data in RD, advance pointers/count in WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_reg  <= '0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= word_count;
            // A new accepted request replaces any stale error flag.
            error     <= misaligned;
          end
        end
        S_RD: begin
          data_reg <= mem_rd;
          src_ptr  <= src_ptr + PTR_STEP;
        end
        S_WR: begin
          dst_ptr   <= dst_ptr + PTR_STEP;
          remaining <= remaining - ONE_WORD;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [7:0]  word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  int          we_count;
  int          done_count;
  int          passed;
  int          total;

  dma_copy_engine #(.LEN_W(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed RAM model with combinational read, write at posedge.
  assign mem_rd = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_address[7:2]] = mem_wd;
      we_count = we_count + 1;
    end
    if (done) done_count = done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Inputs may move after the start edge without affecting the transfer.
    src_addr   = 32'hDEAD_BEE0;
    dst_addr   = 32'hDEAD_BEE0;
    word_count = 8'hFF;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    we_count   = 0;
    done_count = 0;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    clear_mem();

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wd", mem_wd, 32'h0);
    reset = 1'b0;
    tick();

    // Basic copy: 4 words 0x00 -> 0x40
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    we_count = 0; done_count = 0;
    issue(32'h00, 32'h40, 8'd4);            // now in cycle k+1 (RD)
    check("basic_rd_busy", {31'b0, busy}, 32'h1);
    check("basic_rd_addr", mem_address, 32'h00);
    check("basic_rd_we", {31'b0, mem_we}, 32'h0);
    tick();                                  // k+2 (WR)
    check("basic_wr_addr", mem_address, 32'h40);
    check("basic_wr_wd", mem_wd, 32'h11);
    check("basic_wr_we", {31'b0, mem_we}, 32'h1);
    for (int i = 0; i < 6; i++) tick();      // k+8: last WR
    check("basic_last_wr_addr", mem_address, 32'h4C);
    check("basic_pre_done", {31'b0, done}, 32'h0);
    tick();                                  // k+9: DONE
    check("basic_done", {31'b0, done}, 32'h1);
    check("basic_done_busy", {31'b0, busy}, 32'h0);
    check("basic_error", {31'b0, error}, 32'h0);
    check("basic_we_count", we_count, 32'd4);
    check("basic_m16", mem[16], 32'h11);
    check("basic_m17", mem[17], 32'h22);
    check("basic_m18", mem[18], 32'h33);
    check("basic_m19", mem[19], 32'h44);
    tick();
    check("basic_done_pulse", {31'b0, done}, 32'h0);

    // Zero length
    we_count = 0;
    issue(32'h00, 32'h80, 8'd0);
    check("zero_done", {31'b0, done}, 32'h1);
    check("zero_error", {31'b0, error}, 32'h0);
    tick();
    check("zero_we_count", we_count, 32'd0);
    check("zero_idle_done", {31'b0, done}, 32'h0);

    // Misaligned source
    we_count = 0;
    issue(32'h02, 32'h40, 8'd2);
    check("mis_done", {31'b0, done}, 32'h1);
    check("mis_error", {31'b0, error}, 32'h1);
    tick();
    tick();
    check("mis_error_held", {31'b0, error}, 32'h1);
    check("mis_we_count", we_count, 32'd0);
    issue(32'h00, 32'h60, 8'd1);
    check("mis_error_clear", {31'b0, error}, 32'h0);
    check("mis_next_busy", {31'b0, busy}, 32'h1);
    tick();
    tick();
    check("mis_next_done", {31'b0, done}, 32'h1);
    check("mis_next_m24", mem[24], 32'h11);
    tick();

    // Overlapping forward copy
    clear_mem();
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h4;
    issue(32'h00, 32'h04, 8'd3);
    for (int i = 0; i < 6; i++) tick();      // k+7: DONE
    check("ovl_done", {31'b0, done}, 32'h1);
    check("ovl_m0", mem[0], 32'h1);
    check("ovl_m1", mem[1], 32'h1);
    check("ovl_m2", mem[2], 32'h1);
    check("ovl_m3", mem[3], 32'h1);
    tick();

    // Reset during the third write
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + i;
    we_count = 0;
    issue(32'h00, 32'h80, 8'd8);
    for (int i = 0; i < 5; i++) tick();      // k+6: third WR
    check("rst_mid_wr_we", {31'b0, mem_we}, 32'h1);
    check("rst_mid_wr_addr", mem_address, 32'h88);
    reset = 1'b1;
    #1;
    check("rst_mid_we", {31'b0, mem_we}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_addr", mem_address, 32'h0);
    check("rst_mid_wd", mem_wd, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_we_count", we_count, 32'd2);
    check("rst_mid_m32", mem[32], 32'hA0);
    check("rst_mid_m33", mem[33], 32'hA1);
    check("rst_mid_m34", mem[34], 32'h0);
    issue(32'h00, 32'hC0, 8'd1);
    tick();
    tick();
    check("rst_after_done", {31'b0, done}, 32'h1);
    check("rst_after_m48", mem[48], 32'hA0);
    tick();

    // Start while busy is ignored
    we_count = 0; done_count = 0;
    issue(32'h00, 32'hE0, 8'd2);             // k+1: RD
    src_addr   = 32'h10;
    dst_addr   = 32'hF0;
    word_count = 8'd3;
    start      = 1'b1;
    tick();                                  // k+2
    start      = 1'b0;
    tick();                                  // k+3
    tick();                                  // k+4
    check("busy_ign_pre_done", {31'b0, done}, 32'h0);
    tick();                                  // k+5: DONE
    check("busy_ign_done", {31'b0, done}, 32'h1);
    for (int i = 0; i < 6; i++) tick();
    check("busy_ign_done_count", done_count, 32'd1);
    check("busy_ign_we_count", we_count, 32'd2);
    check("busy_ign_m56", mem[56], 32'hA0);
    check("busy_ign_m57", mem[57], 32'hA1);
    check("busy_ign_m60", mem[60], 32'h0);
    check("busy_ign_idle", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
